led_pattern_seq: RTL and testbench

//  Parametrised LED pattern sequencer; next generation of the board's running-light block.
//  - Steps an LED_W-wide pattern once per programmable tick.
//  - Four run-time modes (fill-shift, walk, bounce, blink), selectable direction and speed.
//  - Run/pause control. Optional PWM brightness gating.
//  - Sits between the board clock and the LED pins. Also exports a step strobe for other demos.

---
 rtl/led_pattern_seq.sv | 135 +++++++++++++
 tb/tb_led_pattern_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// Running-light LED sequencer: fill, walk, bounce and blink patterns stepped at a programmable rate.
// Define LED_PWM_EN to gate the LED drive with a 15-slot PWM brightness control.
module led_pattern_seq #(
  parameter int LED_W = 8,
  parameter int DIV   = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [1:0]       speed,
  input  logic [3:0]       bright,
  output logic [LED_W-1:0] led,
  output logic             step_tk
);

  typedef enum logic [1:0] {
    MODE_FILL   = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  localparam int CW = $clog2(DIV);
  localparam logic [LED_W-1:0] LSB_HOT = LED_W'(1);
  localparam logic [LED_W-1:0] MSB_HOT = LSB_HOT << (LED_W - 1);

  logic [CW-1:0]    cnt;
  logic [LED_W-1:0] pat;
  logic [LED_W-1:0] pat_nxt;
  logic [LED_W-1:0] seed;
  mode_t            mode_q;
  mode_t            mode_in;
  logic             bdir;
  logic             bdir_nxt;
  logic             chg;
  logic             tick;
  logic             step_pend;
  logic [31:0]      lim;

  // Comparing with >= lets a mid-count speed increase tick at once instead of wrapping.
  assign mode_in = mode_t'(mode);
  assign chg     = (mode_in != mode_q);
  assign lim     = (32'(DIV) >> speed) - 32'd1;
  assign tick    = en && (32'(cnt) >= lim);

  always_comb begin
    seed = '1;
    if (mode_in == MODE_WALK || mode_in == MODE_BOUNCE) begin
      seed = dir ? MSB_HOT : LSB_HOT;
    end
  end

  always_comb begin
    pat_nxt  = pat;
    bdir_nxt = bdir;
    case (mode_q)
      MODE_FILL: begin
        if (pat == '0) pat_nxt = '1;
        else           pat_nxt = dir ? (pat >> 1) : (pat << 1);
      end
      MODE_WALK: begin
        pat_nxt = dir ? {pat[0], pat[LED_W-1:1]} : {pat[LED_W-2:0], pat[LED_W-1]};
      end
      MODE_BOUNCE: begin
        // Reaching an end flips direction and moves away in the same step.
        if (!bdir && pat[LED_W-1]) begin
          bdir_nxt = 1'b1;
          pat_nxt  = pat >> 1;
        end else if (bdir && pat[0]) begin
          bdir_nxt = 1'b0;
          pat_nxt  = pat << 1;
        end else begin
          pat_nxt = bdir ? (pat >> 1) : (pat << 1);
        end
      end
      MODE_BLINK: pat_nxt = ~pat;
      default:    pat_nxt = pat;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      pat       <= '1;
      mode_q    <= MODE_FILL;
      bdir      <= 1'b0;
      step_pend <= 1'b0;
    end else if (chg) begin
      mode_q    <= mode_in;
      cnt       <= '0;
      pat       <= seed;
      step_pend <= 1'b0;
      if (mode_in == MODE_BOUNCE) bdir <= dir;
    end else if (tick) begin
      cnt       <= '0;
      pat       <= pat_nxt;
      bdir      <= bdir_nxt;
      step_pend <= 1'b1;
    end else begin
      step_pend <= 1'b0;
      if (en) cnt <= cnt + CW'(1);
    end
  end

  // step_tk trails the pattern update by one cycle so it lines up with led.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_tk <= 1'b0;
    else     step_tk <= step_pend;
  end

`ifdef LED_PWM_EN
  logic [3:0] pcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= 4'd0;
      led  <= '1;
    end else begin
      pcnt <= (pcnt == 4'd14) ? 4'd0 : pcnt + 4'd1;
      led  <= pat & {LED_W{pcnt < bright}};
    end
  end
`else
  logic unused_bright;
  assign unused_bright = ^bright;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= '1;
    else     led <= pat;
  end
`endif

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with DIV=8, LED_W=8; step order and spacing are hand-derived.
// The brightness checks follow LED_PWM_EN the same way the design does.
module tb_led_pattern_seq;

  localparam int LED_W = 8;
  localparam int DIV   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic [1:0]       speed;
  logic [3:0]       bright;
  logic [LED_W-1:0] led;
  logic             step_tk;

  int check_count = 0;
  int error_count = 0;
  logic [LED_W-1:0] exp_seq[$];

  led_pattern_seq #(.LED_W(LED_W), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .speed(speed), .bright(bright), .led(led), .step_tk(step_tk)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", error_count);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic d, input logic [1:0] s);
    en    = e;
    mode  = m;
    dir   = d;
    speed = s;
  endtask

  // Counts negedges up to and including the one where step_tk is seen high.
  task automatic waitStep(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_tk && n < 200);
    if (!step_tk) checkOutput("step_timeout", 32'd0, 32'd1);
  endtask

  task automatic runSteps(input string tag, input int first_n, input int period);
    int n;
    for (int i = 0; i < exp_seq.size(); i++) begin
      waitStep(n);
      checkOutput($sformatf("%s_led%0d", tag, i), 32'(led), 32'(exp_seq[i]));
      if (i == 0) checkOutput($sformatf("%s_first_gap", tag), n, first_n);
      else        checkOutput($sformatf("%s_gap%0d", tag, i), n, period);
    end
  endtask

  initial begin
    int n;
    int on_cnt;
    int bad_cnt;
    int stk_cnt;

    rst    = 1'b1;
    bright = 4'd15;
    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset_led", 32'(led), 32'hFF);
    checkOutput("reset_step", 32'(step_tk), 32'd0);

    rst = 1'b0;
    exp_seq = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'hFF};
    runSteps("fill", 9, 8);

    applyStimulus(1'b1, 2'd1, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    checkOutput("walk_seed", 32'(led), 32'h01);
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    runSteps("walk_left", 8, 8);
    dir = 1'b1;
    exp_seq = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    runSteps("walk_right", 8, 8);

    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    checkOutput("bounce_seed", 32'(led), 32'h01);
    dir = 1'b1;
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    runSteps("bounce", 8, 8);
    speed = 2'd2;
    exp_seq = '{8'h04, 8'h08, 8'h10};
    runSteps("bounce_fast", 2, 2);

    applyStimulus(1'b1, 2'd0, 1'b0, 2'd0);
    repeat (8) @(negedge clk);
    checkOutput("fill_reseed", 32'(led), 32'hFF);
    mode = 2'd3;
    waitStep(n);
    checkOutput("chg_at_tick_gap", n, 10);
    checkOutput("blink_led", 32'(led), 32'h00);

    en = 1'b0;
    bad_cnt = 0;
    stk_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (led !== 8'h00) bad_cnt++;
      if (step_tk !== 1'b0) stk_cnt++;
    end
    checkOutput("pause_led_changes", bad_cnt, 0);
    checkOutput("pause_step_pulses", stk_cnt, 0);
    en = 1'b1;
    waitStep(n);
    checkOutput("resume_gap", n, 8);
    checkOutput("resume_led", 32'(led), 32'hFF);

    applyStimulus(1'b1, 2'd2, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    checkOutput("bounce2_seed", 32'(led), 32'h01);
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    runSteps("bounce2", 8, 8);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_led", 32'(led), 32'hFF);
    checkOutput("async_rst_step", 32'(step_tk), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_led", 32'(led), 32'hFF);
    @(negedge clk);
    checkOutput("post_rst_seed", 32'(led), 32'h01);
    waitStep(n);
    checkOutput("post_rst_gap", n, 8);
    checkOutput("post_rst_step", 32'(led), 32'h02);

    applyStimulus(1'b0, 2'd3, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    checkOutput("chg_while_paused", 32'(led), 32'hFF);

`ifdef LED_PWM_EN
    bright = 4'd5;
    repeat (2) @(negedge clk);
    on_cnt  = 0;
    bad_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (led === 8'hFF) on_cnt++;
      else if (led !== 8'h00) bad_cnt++;
    end
    checkOutput("pwm5_on", on_cnt, 10);
    checkOutput("pwm5_other", bad_cnt, 0);

    bright = 4'd0;
    repeat (2) @(negedge clk);
    on_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (led !== 8'h00) on_cnt++;
    end
    checkOutput("pwm0_on", on_cnt, 0);

    bright = 4'd15;
    repeat (2) @(negedge clk);
    on_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (led === 8'hFF) on_cnt++;
    end
    checkOutput("pwm15_on", on_cnt, 15);
`else
    bright = 4'd0;
    repeat (2) @(negedge clk);
    on_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (led === 8'hFF) on_cnt++;
    end
    checkOutput("bright_ignored", on_cnt, 15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
